axi_rd_arbiter: RTL and testbench
=================================

# axi_rd_arbiter

Round-robin arbiter that shares a single AXI4 read master port between `S_COUNT` requester ports. It accepts one read burst at a time, forwards it on the AR channel, and routes the R beats back to the granted requester. The master port is locked until the final beat. The block sits between multiple DMA/test-driver read engines and one AXI4 slave (memory model or interconnect port). It also regenerates `rlast` from its own beat counter and flags any mismatch against the downstream `rlast`.

## Interface
- `S_COUNT`, 2: number of requester ports (≥2).
- `DATA_WIDTH`, 32: R data width.
- `ADDR_WIDTH`, 32: address width.
- `ID_WIDTH`, 8: ID width, passed through unchanged.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_axi_arid` / `s_axi_araddr`  in  S_COUNT*ID_WIDTH / S_COUNT*ADDR_WIDTH  per-port AR id/address; port i occupies slice i.
- `s_axi_arlen` / `s_axi_arsize` / `s_axi_arburst` / `s_axi_arprot`  in  S_COUNT*8 / *3 / *2 / *3  per-port AR burst fields.
- `s_axi_arvalid`  in  S_COUNT  per-port AR valid.
- `s_axi_arready`  out  S_COUNT  per-port AR ready; at most one bit high.
- `s_axi_rid` / `s_axi_rdata` / `s_axi_rresp`  out  S_COUNT*ID_WIDTH / S_COUNT*DATA_WIDTH / S_COUNT*2  R payload, broadcast to every slice.
- `s_axi_rlast`  out  S_COUNT  counter-generated last, broadcast.
- `s_axi_rvalid`  out  S_COUNT  R valid, granted port only.
- `s_axi_rready`  in  S_COUNT  per-port R ready.
- `m_axi_arid`, `m_axi_araddr`, `m_axi_arlen`, `m_axi_arsize`, `m_axi_arburst`, `m_axi_arprot`  out  ID_WIDTH, ADDR_WIDTH, 8, 3, 2, 3  registered AR fields.
- `m_axi_arlock` / `m_axi_arcache` / `m_axi_arqos` / `m_axi_arregion`  out  1/4/4/4  constants 0 / 4'b0011 / 0 / 0.
- `m_axi_arvalid`  out  1  registered AR valid.
- `m_axi_arready`  in  1  AR ready.
- `m_axi_rid`, `m_axi_rdata`, `m_axi_rresp`, `m_axi_rlast`, `m_axi_rvalid`  in  ID_WIDTH, DATA_WIDTH, 2, 1, 1  R channel.
- `m_axi_rready`  out  1  R ready.
- `busy`  out  1  high in ADDR or DATA.
- `grant`  out  $clog2(S_COUNT)  index of the current/last granted port.
- `rlast_err`  out  1  one-cycle pulse on an `rlast` mismatch.

## Operation
- FSM with three states:
  - IDLE: if any `s_axi_arvalid`, pick winner g by round robin, searching from `last_grant+1` with wrap. Assert `s_axi_arready[g]` combinationally that cycle. On the handshake, latch port g's AR fields into the `m_axi_ar*` registers, latch `arlen` into `len_q`, clear `beat_cnt`, set `grant`=g, and go to ADDR.
  - ADDR: `m_axi_arvalid`=1 with fields held stable. On `m_axi_arready`, go to DATA.
  - DATA: `m_axi_rready` = `s_axi_rready[g]`; `s_axi_rvalid[g]` = `m_axi_rvalid`; all other `s_axi_rvalid` bits are 0. `s_axi_rlast` = (`beat_cnt` == `len_q`). Each beat handshake increments the 8-bit `beat_cnt`. On the beat where `beat_cnt == len_q`, set `last_grant`=g and go to IDLE.
- `rlast_err` pulses on any DATA beat handshake where `m_axi_rlast` ≠ (`beat_cnt == len_q`). The burst still ends by the counter, so a downstream slave that drops or doubles `rlast` cannot hang the arbiter.
- `s_axi_arready` is 0 outside IDLE; `m_axi_rready` is 0 outside DATA.
- `arlen`=255 gives 256 beats. `beat_cnt` never wraps, because the burst ends at `len_q`.
- Single request: the winner is that port regardless of `last_grant`.

## Timing
- Reset values:
  - state IDLE, `busy` 0.
  - `m_axi_arvalid` 0, all `m_axi_ar*` field registers 0.
  - `s_axi_arready` 0, `s_axi_rvalid` 0, `m_axi_rready` 0, `rlast_err` 0.
  - `grant` 0, `last_grant` S_COUNT-1, so port 0 wins first.
- AR latency: the handshake in IDLE at cycle t gives `m_axi_arvalid`=1 at t+1.
- R path: combinational, zero added latency.
- Back-to-back: last beat at cycle n → IDLE at n+1, next accept at n+1, `m_axi_arvalid` at n+2.
- `s_axi_arvalid` dropping before grant: no effect; arbitration re-evaluates every IDLE cycle.
- Reset mid-burst: returns to IDLE immediately. Outstanding downstream beats are not drained; the system resets the slave together with this block.

## Test plan
- Single port: port 0 issues araddr=0x1000, arlen=3 → `m_axi_arvalid` 1 cycle after accept; 4 beats delivered to port 0 only; `s_axi_rlast` on beat 4; `busy` low the next cycle.
- Contention: both ports request continuously → grants alternate 0,1,0,1 across four bursts; ids and addresses match the granting port.
- Backpressure: port 1 `s_axi_rready` toggles 1010 with `m_axi_arready` delayed 3 cycles → `m_axi_rready` mirrors it; no beat lost or duplicated; data order preserved.
- rlast fault: arlen=1 and slave asserts `m_axi_rlast` on beat 1 → `rlast_err` pulses once; burst ends after beat 2 as counted; the next request is accepted normally.
- Maximum burst: arlen=255 → exactly 256 beats; `s_axi_rlast` only on beat 256; no wrap.
- Reset mid-DATA after 2 of 8 beats → next cycle all outputs at reset values; port 0 wins the first post-reset request.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master port among S_COUNT requesters.
// One burst in flight at a time; rlast is regenerated from a beat counter and checked.
//
// state | meaning
// IDLE  | arbitrate, arready to winner
// ADDR  | AR held on master port, waiting arready
// DATA  | R beats routed to granted port until counted last
module axi_rd_arbiter #(
  parameter  int S_COUNT    = 2,
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 32,
  parameter  int ID_WIDTH   = 8,
  localparam int GW         = $clog2(S_COUNT)
) (
  input  logic                           clk,
  input  logic                           rst,

  input  logic [S_COUNT*ID_WIDTH-1:0]    s_axi_arid,
  input  logic [S_COUNT*ADDR_WIDTH-1:0]  s_axi_araddr,
  input  logic [S_COUNT*8-1:0]           s_axi_arlen,
  input  logic [S_COUNT*3-1:0]           s_axi_arsize,
  input  logic [S_COUNT*2-1:0]           s_axi_arburst,
  input  logic [S_COUNT*3-1:0]           s_axi_arprot,
  input  logic [S_COUNT-1:0]             s_axi_arvalid,
  output logic [S_COUNT-1:0]             s_axi_arready,
  output logic [S_COUNT*ID_WIDTH-1:0]    s_axi_rid,
  output logic [S_COUNT*DATA_WIDTH-1:0]  s_axi_rdata,
  output logic [S_COUNT*2-1:0]           s_axi_rresp,
  output logic [S_COUNT-1:0]             s_axi_rlast,
  output logic [S_COUNT-1:0]             s_axi_rvalid,
  input  logic [S_COUNT-1:0]             s_axi_rready,

  output logic [ID_WIDTH-1:0]            m_axi_arid,
  output logic [ADDR_WIDTH-1:0]          m_axi_araddr,
  output logic [7:0]                     m_axi_arlen,
  output logic [2:0]                     m_axi_arsize,
  output logic [1:0]                     m_axi_arburst,
  output logic [2:0]                     m_axi_arprot,
  output logic                           m_axi_arlock,
  output logic [3:0]                     m_axi_arcache,
  output logic [3:0]                     m_axi_arqos,
  output logic [3:0]                     m_axi_arregion,
  output logic                           m_axi_arvalid,
  input  logic                           m_axi_arready,
  input  logic [ID_WIDTH-1:0]            m_axi_rid,
  input  logic [DATA_WIDTH-1:0]          m_axi_rdata,
  input  logic [1:0]                     m_axi_rresp,
  input  logic                           m_axi_rlast,
  input  logic                           m_axi_rvalid,
  output logic                           m_axi_rready,

  output logic                           busy,
  output logic [GW-1:0]                  grant,
  output logic                           rlast_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [GW-1:0]           r_grant;
  logic [GW-1:0]           r_last_grant;
  logic [7:0]              r_len;
  logic [7:0]              r_beat_cnt;
  logic                    r_arvalid;
  logic [ID_WIDTH-1:0]     r_arid;
  logic [ADDR_WIDTH-1:0]   r_araddr;
  logic [7:0]              r_arlen;
  logic [2:0]              r_arsize;
  logic [1:0]              r_arburst;
  logic [2:0]              r_arprot;

  logic                    w_any;
  logic [GW-1:0]           w_winner;
  logic [GW-1:0]           w_cand;
  logic                    w_ar_hs;
  logic                    w_r_hs;
  logic                    w_cnt_last;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    w_any    = 1'b0;
    w_winner = r_last_grant;
    w_cand   = r_last_grant;
    for (int k = 1; k <= S_COUNT; k++) begin
      w_cand = GW'((int'(r_last_grant) + k) % S_COUNT);
      if (!w_any && s_axi_arvalid[w_cand]) begin
        w_any    = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  assign w_ar_hs    = (r_state == ST_IDLE) && w_any;
  assign w_cnt_last = (r_beat_cnt == r_len);
  assign w_r_hs     = (r_state == ST_DATA) && m_axi_rvalid && s_axi_rready[r_grant];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any)                   w_state_nxt = ST_ADDR;
      ST_ADDR: if (m_axi_arready)           w_state_nxt = ST_DATA;
      ST_DATA: if (w_r_hs && w_cnt_last)    w_state_nxt = ST_IDLE;
      default:                              w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = '0;
    s_axi_rvalid  = '0;
    s_axi_rlast   = '0;
    m_axi_rready  = 1'b0;
    rlast_err     = 1'b0;
    busy          = (r_state != ST_IDLE);
    if (r_state == ST_IDLE && w_any) begin
      s_axi_arready[w_winner] = 1'b1;
    end
    if (r_state == ST_DATA) begin
      m_axi_rready          = s_axi_rready[r_grant];
      s_axi_rvalid[r_grant] = m_axi_rvalid;
      s_axi_rlast           = {S_COUNT{w_cnt_last}};
      rlast_err             = w_r_hs && (m_axi_rlast != w_cnt_last);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant      <= '0;
      r_last_grant <= GW'(S_COUNT - 1);
      r_len        <= '0;
      r_beat_cnt   <= '0;
      r_arvalid    <= 1'b0;
      r_arid       <= '0;
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_arsize     <= '0;
      r_arburst    <= '0;
      r_arprot     <= '0;
    end else begin
      if (w_ar_hs) begin
        r_arid     <= s_axi_arid[w_winner*ID_WIDTH +: ID_WIDTH];
        r_araddr   <= s_axi_araddr[w_winner*ADDR_WIDTH +: ADDR_WIDTH];
        r_arlen    <= s_axi_arlen[w_winner*8 +: 8];
        r_arsize   <= s_axi_arsize[w_winner*3 +: 3];
        r_arburst  <= s_axi_arburst[w_winner*2 +: 2];
        r_arprot   <= s_axi_arprot[w_winner*3 +: 3];
        r_len      <= s_axi_arlen[w_winner*8 +: 8];
        r_beat_cnt <= '0;
        r_grant    <= w_winner;
        r_arvalid  <= 1'b1;
      end
      if (r_state == ST_ADDR && m_axi_arready) begin
        r_arvalid <= 1'b0;
      end
      // Counter stops at len so a 256-beat burst never wraps it.
      if (w_r_hs) begin
        if (w_cnt_last) begin
          r_last_grant <= r_grant;
        end else begin
          r_beat_cnt <= r_beat_cnt + 8'd1;
        end
      end
    end
  end

  assign s_axi_rid   = {S_COUNT{m_axi_rid}};
  assign s_axi_rdata = {S_COUNT{m_axi_rdata}};
  assign s_axi_rresp = {S_COUNT{m_axi_rresp}};

  assign m_axi_arid     = r_arid;
  assign m_axi_araddr   = r_araddr;
  assign m_axi_arlen    = r_arlen;
  assign m_axi_arsize   = r_arsize;
  assign m_axi_arburst  = r_arburst;
  assign m_axi_arprot   = r_arprot;
  assign m_axi_arvalid  = r_arvalid;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = 4'b0011;
  assign m_axi_arqos    = 4'd0;
  assign m_axi_arregion = 4'd0;

  assign grant = r_grant;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed + randomized bench for axi_rd_arbiter with a round-robin and beat-count model.
module tb_axi_rd_arbiter;
  localparam int S  = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [S*IW-1:0] s_axi_arid;
  logic [S*AW-1:0] s_axi_araddr;
  logic [S*8-1:0]  s_axi_arlen;
  logic [S*3-1:0]  s_axi_arsize;
  logic [S*2-1:0]  s_axi_arburst;
  logic [S*3-1:0]  s_axi_arprot;
  logic [S-1:0]    s_axi_arvalid;
  logic [S-1:0]    s_axi_arready;
  logic [S*IW-1:0] s_axi_rid;
  logic [S*DW-1:0] s_axi_rdata;
  logic [S*2-1:0]  s_axi_rresp;
  logic [S-1:0]    s_axi_rlast;
  logic [S-1:0]    s_axi_rvalid;
  logic [S-1:0]    s_axi_rready;
  logic [IW-1:0]   m_axi_arid;
  logic [AW-1:0]   m_axi_araddr;
  logic [7:0]      m_axi_arlen;
  logic [2:0]      m_axi_arsize;
  logic [1:0]      m_axi_arburst;
  logic [2:0]      m_axi_arprot;
  logic            m_axi_arlock;
  logic [3:0]      m_axi_arcache;
  logic [3:0]      m_axi_arqos;
  logic [3:0]      m_axi_arregion;
  logic            m_axi_arvalid;
  logic            m_axi_arready;
  logic [IW-1:0]   m_axi_rid;
  logic [DW-1:0]   m_axi_rdata;
  logic [1:0]      m_axi_rresp;
  logic            m_axi_rlast;
  logic            m_axi_rvalid;
  logic            m_axi_rready;
  logic            busy;
  logic [0:0]      grant;
  logic            rlast_err;

  axi_rd_arbiter #(.S_COUNT(S), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arprot(m_axi_arprot),
    .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache), .m_axi_arqos(m_axi_arqos),
    .m_axi_arregion(m_axi_arregion), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .busy(busy), .grant(grant), .rlast_err(rlast_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int m_last = S - 1;

  logic [IW-1:0] f_id[S];
  logic [AW-1:0] f_addr[S];
  logic [7:0]    f_len[S];
  logic [2:0]    f_size[S];
  logic [1:0]    f_burst[S];
  logic [2:0]    f_prot[S];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] addr, input logic [7:0] len);
    f_id[p]    = IW'($urandom);
    f_addr[p]  = addr;
    f_len[p]   = len;
    f_size[p]  = 3'($urandom_range(0, 2));
    f_burst[p] = 2'($urandom_range(0, 2));
    f_prot[p]  = 3'($urandom);
    s_axi_arid[p*IW +: IW]   = f_id[p];
    s_axi_araddr[p*AW +: AW] = f_addr[p];
    s_axi_arlen[p*8 +: 8]    = f_len[p];
    s_axi_arsize[p*3 +: 3]   = f_size[p];
    s_axi_arburst[p*2 +: 2]  = f_burst[p];
    s_axi_arprot[p*3 +: 3]   = f_prot[p];
  endtask

  // Reference arbitration: ports in the order following the last winner, first requester wins.
  function automatic int pick(input logic [S-1:0] mask);
    int order[$];
    for (int i = 0; i < S; i++) order.push_back(i);
    for (int i = 0; i <= m_last; i++) order.push_back(order.pop_front());
    foreach (order[i]) if (((mask >> order[i]) & S'(1)) != '0) return order[i];
    return -1;
  endfunction

  task automatic burst(input logic [S-1:0] vmask, input int ar_delay, input int bp_mode,
                       input int bad_beat, input int stop_after);
    int w, nb, k, seen, cyc, errs, exp_errs;
    logic exp_last, rr;
    logic [DW-1:0] d;
    s_axi_arvalid = vmask;
    w = pick(vmask);
    #1;
    chk("arready_win", s_axi_arready, 64'(1) << w);
    chk("busy_idle", busy, 0);
    @(posedge clk); #1;
    s_axi_arvalid = s_axi_arvalid & ~(S'(1) << w);
    #1;
    chk("arvalid_t1", m_axi_arvalid, 1);
    chk("araddr", m_axi_araddr, f_addr[w]);
    chk("arid", m_axi_arid, f_id[w]);
    chk("arlen", m_axi_arlen, f_len[w]);
    chk("arfields", {m_axi_arsize, m_axi_arburst, m_axi_arprot}, {f_size[w], f_burst[w], f_prot[w]});
    chk("grant", grant, w);
    chk("busy_addr", busy, 1);
    chk("arready_addr", s_axi_arready, 0);
    for (int i = 0; i < ar_delay; i++) begin
      @(posedge clk); #1;
      chk("arvalid_hold", m_axi_arvalid, 1);
      chk("araddr_hold", m_axi_araddr, f_addr[w]);
      chk("rready_addr", m_axi_rready, 0);
    end
    m_axi_arready = 1'b1;
    @(posedge clk); #1;
    m_axi_arready = 1'b0;
    chk("arvalid_done", m_axi_arvalid, 0);
    nb = int'(f_len[w]) + 1;
    k = 0; seen = 0; cyc = 0; errs = 0; exp_errs = 0;
    while (k < nb && k != stop_after && cyc < nb * 8 + 64) begin
      m_axi_rvalid = (bp_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      d = $urandom;
      m_axi_rdata = d;
      m_axi_rid = f_id[w];
      m_axi_rresp = 2'($urandom);
      exp_last = (k == int'(f_len[w]));
      m_axi_rlast = exp_last ^ (k == bad_beat);
      case (bp_mode)
        0: rr = 1'b1;
        1: rr = (cyc % 2 == 0);
        default: rr = 1'($urandom);
      endcase
      s_axi_rready = S'($urandom);
      s_axi_rready = (s_axi_rready & ~(S'(1) << w)) | (S'(rr) << w);
      #1;
      chk("m_rready", m_axi_rready, rr);
      chk("s_rvalid", s_axi_rvalid, m_axi_rvalid ? (64'(1) << w) : 64'(0));
      chk("arready_data", s_axi_arready, 0);
      chk("busy_data", busy, 1);
      if (((s_axi_rvalid >> w) & S'(1)) != '0 && rr) seen++;
      if (m_axi_rvalid && rr) begin
        chk("rdata", DW'(s_axi_rdata >> (w * DW)), d);
        chk("rid_resp", {IW'(s_axi_rid >> (w * IW)), 2'(s_axi_rresp >> (w * 2))}, {f_id[w], m_axi_rresp});
        chk("rlast", 1'(s_axi_rlast >> w), exp_last);
        chk("rlast_err", rlast_err, exp_last != m_axi_rlast);
        if (exp_last != m_axi_rlast) exp_errs++;
        k++;
      end else begin
        chk("rlast_err_idle", rlast_err, 0);
      end
      if (rlast_err) errs++;
      @(posedge clk); #1;
      cyc++;
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast = 1'b0;
    s_axi_rready = '0;
    if (stop_after < 0) begin
      #1;
      chk("beats_seen", seen, nb);
      chk("busy_end", busy, 0);
      chk("err_pulses", errs, exp_errs);
      m_last = w;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [S-1:0] mask;
    rst = 1'b1;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arprot = '0; s_axi_arvalid = '0; s_axi_rready = '0;
    m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_arfields", {m_axi_arid, m_axi_araddr, m_axi_arlen}, 0);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_rlast_err", rlast_err, 0);
    chk("rst_grant", grant, 0);
    chk("const_ar", {m_axi_arlock, m_axi_arcache, m_axi_arqos, m_axi_arregion}, {1'b0, 4'b0011, 4'd0, 4'd0});

    // single port, address 0x1000, four beats
    set_port(0, 32'h1000, 8'd3);
    burst(2'b01, 0, 0, -1, -1);
    // same port again alone wins despite last grant
    set_port(0, $urandom, 8'd0);
    burst(2'b01, 1, 2, -1, -1);

    // contention: both request continuously, grants alternate
    set_port(0, $urandom, 8'd2);
    set_port(1, $urandom, 8'd1);
    for (int i = 0; i < 4; i++) begin
      burst(2'b11, $urandom_range(0, 2), 0, -1, -1);
      set_port(m_last, $urandom, 8'($urandom_range(0, 3)));
    end

    // backpressure on port 1 with a slow AR slave
    set_port(1, $urandom, 8'd5);
    burst(2'b10, 3, 1, -1, -1);

    // downstream rlast early on beat 1 of a 2-beat burst
    set_port(0, $urandom, 8'd1);
    burst(2'b01, 0, 0, 0, -1);
    #1;
    chk("idle_no_req", s_axi_arready, 0);
    set_port(1, $urandom, 8'd2);
    burst(2'b10, 1, 0, -1, -1);

    // maximum burst length
    set_port(1, $urandom, 8'd255);
    burst(2'b10, 0, 2, -1, -1);

    // randomized mix
    for (int i = 0; i < 8; i++) begin
      mask = S'($urandom_range(1, 3));
      for (int p = 0; p < S; p++) set_port(p, $urandom, 8'($urandom_range(0, 15)));
      burst(mask, $urandom_range(0, 3), $urandom_range(0, 2),
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1, -1);
    end

    // reset after 2 of 8 beats
    set_port(1, $urandom, 8'd7);
    burst(2'b10, 0, 0, -1, 2);
    m_axi_rvalid = 1'b1;
    s_axi_rready = '1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_arvalid", m_axi_arvalid, 0);
    chk("mid_rst_arfields", {m_axi_arid, m_axi_araddr, m_axi_arlen}, 0);
    chk("mid_rst_rvalid", s_axi_rvalid, 0);
    chk("mid_rst_rready", m_axi_rready, 0);
    chk("mid_rst_rlast_err", rlast_err, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_arready", s_axi_arready, 0);
    m_axi_rvalid = 1'b0;
    s_axi_rready = '0;
    rst = 1'b0;
    m_last = S - 1;
    set_port(0, $urandom, 8'd1);
    set_port(1, $urandom, 8'd1);
    burst(2'b11, 0, 0, -1, -1);
    chk("post_rst_winner", m_last, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
